// File: rtl/ram_arbiter.sv
// Round-robin two-port sequencer for the shared asynchronous 64K x 8 RAM.
// Each access runs SETUP -> ACCESS -> HOLD so the address and data are stable around the chip-select strobe.
module ram_arbiter #(
   parameter int DW            = 8,
   parameter int AW            = 16,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_wdata_oe,
   input  logic [DW-1:0] ram_din,
   output logic          ram_cs_n,
   output logic          ram_rw_n,
   output logic          ram_oe_n
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

   state_t     state;
   logic       we_q;
   logic       grant;
   logic       last_grant;
   logic [3:0] count;
   logic       win;

   // Under contention the port that did not win last time goes next.
   always_comb begin
      win = (req0 && req1) ? ~last_grant : req1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         ram_cs_n     <= 1'b1;
         ram_rw_n     <= 1'b1;
         ram_oe_n     <= 1'b1;
         ram_wdata_oe <= 1'b0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
         rdata        <= '0;
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         last_grant   <= 1'b1;
         grant        <= 1'b0;
         we_q         <= 1'b0;
         count        <= '0;
      end else begin
         // NOTE: non-blocking throughout, so every strobe and ack is a clean
         // register output and the default-low ack below is overridden only
         // by the later assignment on the ACCESS exit edge.
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  grant        <= win;
                  last_grant   <= win;
                  we_q         <= win ? we1 : we0;
                  ram_addr     <= win ? addr1 : addr0;
                  ram_wdata    <= win ? wdata1 : wdata0;
                  ram_wdata_oe <= win ? we1 : we0;
                  state        <= SETUP;
               end
            end
            SETUP: begin
               ram_cs_n <= 1'b0;
               ram_rw_n <= ~we_q;
               ram_oe_n <= we_q;
               count    <= 4'(ACCESS_CYCLES - 1);
               state    <= ACCESS;
            end
            ACCESS: begin
               if (count == 4'd0) begin
                  ram_cs_n <= 1'b1;
                  ram_rw_n <= 1'b1;
                  ram_oe_n <= 1'b1;
                  if (!we_q) rdata <= ram_din;
                  ack0  <= ~grant;
                  ack1  <= grant;
                  state <= HOLD;
               end else begin
                  count <= count - 4'd1;
               end
            end
            HOLD: begin
               // Address and write data stay put through HOLD; only the bus drive drops here.
               ram_wdata_oe <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed timing scenarios plus randomized
// two-port traffic checked against a transaction-level reference model.
module tb_ram_arbiter;
   localparam int DW  = 8;
   localparam int AW  = 16;
   localparam int AC  = 2;
   localparam int AC1 = 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1, ram_wdata_oe, ram_cs_n, ram_rw_n, ram_oe_n;
   logic [DW-1:0] rdata, ram_wdata, ram_din;
   logic [AW-1:0] ram_addr;
   logic          ack0_b, ack1_b, ram_wdata_oe_b, ram_cs_n_b, ram_rw_n_b, ram_oe_n_b;
   logic [DW-1:0] rdata_b, ram_wdata_b, ram_din_b;
   logic [AW-1:0] ram_addr_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_arbiter #(.DW(DW), .AW(AW), .ACCESS_CYCLES(AC)) u_dut (
      .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_wdata_oe(ram_wdata_oe), .ram_din(ram_din), .ram_cs_n(ram_cs_n),
      .ram_rw_n(ram_rw_n), .ram_oe_n(ram_oe_n));

   ram_arbiter #(.DW(DW), .AW(AW), .ACCESS_CYCLES(AC1)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
      .ram_wdata_oe(ram_wdata_oe_b), .ram_din(ram_din_b), .ram_cs_n(ram_cs_n_b),
      .ram_rw_n(ram_rw_n_b), .ram_oe_n(ram_oe_n_b));

   // Asynchronous RAM: power-up content follows init_val until a location is written.
   logic [7:0] mem     [0:65535];
   bit         written [0:65535];

   function automatic logic [7:0] init_val(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h83;
   endfunction

   function automatic logic [7:0] ram_word(input logic [15:0] a);
      return written[a] ? mem[a] : init_val(a);
   endfunction

   always @(posedge clk) begin
      if (!ram_cs_n && !ram_rw_n) begin
         mem[ram_addr]     <= ram_wdata;
         written[ram_addr] <= 1'b1;
      end
   end

   assign ram_din   = (!ram_cs_n && !ram_oe_n) ? ram_word(ram_addr) : 8'hxx;
   assign ram_din_b = (!ram_cs_n_b && !ram_oe_n_b) ? ram_word(ram_addr_b) : 8'hxx;

   task automatic idle_inputs();
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
   endtask

   // Leaves the bench at a cycle start (1 time unit after a rising edge) with the DUT idle.
   task automatic apply_reset();
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // Issues one request for a single cycle and waits (bounded) for its ack.
   task automatic run_txn(input bit port, input bit we, input logic [15:0] a,
                          input logic [7:0] d, output bit acked);
      acked = 1'b0;
      if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
      else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      for (int c = 0; c < 40 && !acked; c++) begin
         @(negedge clk);
         if (port ? ack1 : ack0) acked = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      n_vec++; if ({ram_cs_n, ram_rw_n, ram_oe_n} !== 3'b111) begin n_err++; $display("FAIL reset_strobes: got %b want 111", {ram_cs_n, ram_rw_n, ram_oe_n}); end
      n_vec++; if (ram_wdata_oe !== 1'b0) begin n_err++; $display("FAIL reset_wdata_oe: got %b want 0", ram_wdata_oe); end
      n_vec++; if (ram_addr !== 16'h0000) begin n_err++; $display("FAIL reset_addr: got %h want 0000", ram_addr); end
      n_vec++; if (ram_wdata !== 8'h00) begin n_err++; $display("FAIL reset_wdata: got %h want 00", ram_wdata); end
      n_vec++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", rdata); end
      n_vec++; if ({ack0, ack1} !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %b want 00", {ack0, ack1}); end
   endtask

   // Read of 1234 with req0 pulsed for one cycle; inputs scrambled after grant.
   task automatic test_read_pulse();
      bit exp_cs, exp_cs_b;
      apply_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h1234;
      for (int k = 0; k <= AC + 4; k++) begin
         if (k == 1) begin req0 = 1'b0; we0 = 1'b1; addr0 = 16'hDEAD; end
         @(negedge clk);
         exp_cs   = !(k >= 2 && k <= AC + 1);
         exp_cs_b = !(k >= 2 && k <= AC1 + 1);
         n_vec++; if (ram_cs_n !== exp_cs) begin n_err++; $display("FAIL rd_cs_n c%0d: got %b want %b", k, ram_cs_n, exp_cs); end
         n_vec++; if (ram_oe_n !== exp_cs) begin n_err++; $display("FAIL rd_oe_n c%0d: got %b want %b", k, ram_oe_n, exp_cs); end
         n_vec++; if (ram_rw_n !== 1'b1) begin n_err++; $display("FAIL rd_rw_n c%0d: got %b want 1", k, ram_rw_n); end
         n_vec++; if ({ack0, ack1} !== {k == AC + 2, 1'b0}) begin n_err++; $display("FAIL rd_ack c%0d: got %b want %b", k, {ack0, ack1}, {k == AC + 2, 1'b0}); end
         n_vec++; if (ram_cs_n_b !== exp_cs_b) begin n_err++; $display("FAIL ac1_cs_n c%0d: got %b want %b", k, ram_cs_n_b, exp_cs_b); end
         n_vec++; if (ack0_b !== (k == AC1 + 2)) begin n_err++; $display("FAIL ac1_ack0 c%0d: got %b want %b", k, ack0_b, k == AC1 + 2); end
         @(posedge clk); #1;
      end
      n_vec++; if (rdata !== 8'hA5) begin n_err++; $display("FAIL rd_data: got %h want a5", rdata); end
      n_vec++; if (rdata_b !== 8'hA5) begin n_err++; $display("FAIL ac1_rd_data: got %h want a5", rdata_b); end
   endtask

   task automatic test_write();
      bit exp_low, acked;
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'hFFFF; wdata1 = 8'h3C;
      for (int k = 0; k <= AC + 4; k++) begin
         if (k == 1) begin req1 = 1'b0; addr1 = 16'h0000; wdata1 = 8'h00; end
         @(negedge clk);
         exp_low = (k >= 2 && k <= AC + 1);
         n_vec++; if ({ram_cs_n, ram_rw_n, ram_oe_n} !== {!exp_low, !exp_low, 1'b1}) begin n_err++; $display("FAIL wr_strobes c%0d: got %b want %b", k, {ram_cs_n, ram_rw_n, ram_oe_n}, {!exp_low, !exp_low, 1'b1}); end
         if (k >= 1 && k <= AC + 2) begin
            n_vec++; if ({ram_addr, ram_wdata, ram_wdata_oe} !== {16'hFFFF, 8'h3C, 1'b1}) begin n_err++; $display("FAIL wr_bus c%0d: got %h/%h/%b want ffff/3c/1", k, ram_addr, ram_wdata, ram_wdata_oe); end
         end
         n_vec++; if ({ack0, ack1} !== {1'b0, k == AC + 2}) begin n_err++; $display("FAIL wr_ack c%0d: got %b want %b", k, {ack0, ack1}, {1'b0, k == AC + 2}); end
         @(posedge clk); #1;
      end
      n_vec++; if (rdata !== 8'hA5) begin n_err++; $display("FAIL wr_rdata_kept: got %h want a5", rdata); end
      run_txn(1'b0, 1'b0, 16'hFFFF, 8'h00, acked);
      n_vec++; if (!acked) begin n_err++; $display("FAIL wr_readback_ack: got timeout want ack0"); end
      n_vec++; if (rdata !== 8'h3C) begin n_err++; $display("FAIL wr_readback: got %h want 3c", rdata); end
   endtask

   task automatic test_contention();
      int got[$];
      apply_reset();
      req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0010; addr1 = 16'h0020;
      for (int c = 0; c < 4 * (AC + 3) + 2; c++) begin
         @(negedge clk);
         n_vec++; if (ack0 && ack1) begin n_err++; $display("FAIL rr_both_ack c%0d: got 11 want not both", c); end
         if (ack0) got.push_back(0);
         if (ack1) got.push_back(1);
         @(posedge clk); #1;
      end
      idle_inputs();
      n_vec++; if (got.size() != 4) begin n_err++; $display("FAIL rr_count: got %0d want 4", got.size()); end
      foreach (got[i]) begin
         n_vec++; if (got[i] != i % 2) begin n_err++; $display("FAIL rr_order #%0d: got port %0d want port %0d", i, got[i], i % 2); end
      end
      repeat (AC + 4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      bit acked;
      apply_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0042; wdata0 = 8'h99;
      @(posedge clk); #1;
      req0 = 1'b0;
      @(posedge clk); #1;
      n_vec++; if ({ram_cs_n, ram_rw_n} !== 2'b00) begin n_err++; $display("FAIL rm_in_access: got %b want 00", {ram_cs_n, ram_rw_n}); end
      reset_n = 1'b0;
      #1;
      n_vec++; if ({ram_cs_n, ram_rw_n, ram_oe_n, ram_wdata_oe} !== 4'b1110) begin n_err++; $display("FAIL rm_strobes: got %b want 1110", {ram_cs_n, ram_rw_n, ram_oe_n, ram_wdata_oe}); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++; if ({ack0, ack1} !== 2'b00) begin n_err++; $display("FAIL rm_no_ack c%0d: got %b want 00", c, {ack0, ack1}); end
      end
      @(posedge clk); #1 reset_n = 1'b1;
      for (int c = 0; c < AC + 4; c++) begin
         @(negedge clk);
         n_vec++; if ({ack0, ack1} !== 2'b00) begin n_err++; $display("FAIL rm_no_late_ack c%0d: got %b want 00", c, {ack0, ack1}); end
         @(posedge clk); #1;
      end
      run_txn(1'b0, 1'b0, 16'h0042, 8'h00, acked);
      n_vec++; if (!acked) begin n_err++; $display("FAIL rm_reread_ack: got timeout want ack0"); end
      n_vec++; if (rdata !== init_val(16'h0042)) begin n_err++; $display("FAIL rm_reread: got %h want %h", rdata, init_val(16'h0042)); end
   endtask

   // Transaction-level model: each grant occupies AC+3 cycles, ack on the (AC+2)th.
   task automatic test_random();
      logic [7:0]  ref_mem [int];
      bit          p_valid [2];
      bit          p_we    [2];
      logic [15:0] p_addr  [2];
      logic [7:0]  p_wdata [2];
      int          busy = 0;
      bit          last = 1'b1;
      bit          cur_port = 1'b0, cur_we = 1'b0;
      logic [15:0] cur_addr = '0;
      logic [7:0]  cur_wdata = '0, exp_rdata = 8'h00;
      bit          exp_a0, exp_a1, exp_cs;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!p_valid[p] && c < 370 && $urandom_range(0, 2) == 0) begin
               p_valid[p] = 1'b1;
               p_we[p]    = 1'($urandom_range(0, 1));
               p_addr[p]  = 16'h0100 + 16'($urandom_range(0, 7));
               p_wdata[p] = 8'($urandom);
            end
         end
         req0 = p_valid[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
         req1 = p_valid[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];
         @(negedge clk);
         exp_a0 = 1'b0; exp_a1 = 1'b0;
         if (busy == 0) begin
            if (p_valid[0] || p_valid[1]) begin
               cur_port  = (p_valid[0] && p_valid[1]) ? !last : p_valid[1];
               last      = cur_port;
               cur_we    = p_we[cur_port];
               cur_addr  = p_addr[cur_port];
               cur_wdata = p_wdata[cur_port];
               busy      = AC + 2;
            end
         end else begin
            busy--;
            if (busy == 0) begin
               exp_a0 = !cur_port;
               exp_a1 = cur_port;
               if (cur_we) ref_mem[int'(cur_addr)] = cur_wdata;
               else exp_rdata = ref_mem.exists(int'(cur_addr)) ? ref_mem[int'(cur_addr)] : init_val(cur_addr);
               p_valid[cur_port] = 1'b0;
            end
         end
         exp_cs = !(busy >= 1 && busy <= AC);
         n_vec++; if ({ack0, ack1} !== {exp_a0, exp_a1}) begin n_err++; $display("FAIL rnd_ack c%0d: got %b want %b", c, {ack0, ack1}, {exp_a0, exp_a1}); end
         n_vec++; if (rdata !== exp_rdata) begin n_err++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, rdata, exp_rdata); end
         n_vec++; if (ram_cs_n !== exp_cs) begin n_err++; $display("FAIL rnd_cs_n c%0d: got %b want %b", c, ram_cs_n, exp_cs); end
         if (!exp_cs) begin
            n_vec++; if ({ram_addr, ram_rw_n, ram_oe_n, ram_wdata_oe} !== {cur_addr, !cur_we, cur_we, cur_we}) begin n_err++; $display("FAIL rnd_access c%0d: got %h/%b%b%b want %h/%b%b%b", c, ram_addr, ram_rw_n, ram_oe_n, ram_wdata_oe, cur_addr, !cur_we, cur_we, cur_we); end
            if (cur_we) begin
               n_vec++; if (ram_wdata !== cur_wdata) begin n_err++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, ram_wdata, cur_wdata); end
            end
         end else begin
            n_vec++; if ({ram_rw_n, ram_oe_n} !== 2'b11) begin n_err++; $display("FAIL rnd_idle_strobes c%0d: got %b want 11", c, {ram_rw_n, ram_oe_n}); end
         end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset_n = 1'b0;
      test_reset();
      test_read_pulse();
      test_write();
      test_contention();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
